// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus: program-request, PC, branch/stall control, ROM port and decode output.
interface instr_fetch_stage_if #(
    parameter int A = 10,
    parameter int W = 9
);
    logic         Start;
    logic [A-1:0] ProgCtr;
    logic         Flush;
    logic         Stall;
    logic [W-1:0] Imem_Data;
    logic [A-1:0] Imem_Addr;
    logic         Imem_Rd;
    logic         PcHold;
    logic [W-1:0] Instr;
    logic [A-1:0] InstrPC;
    logic         InstrValid;
    logic         Done;

    // Fetch stage side
    modport slave (
        input  Start, ProgCtr, Flush, Stall, Imem_Data,
        output Imem_Addr, Imem_Rd, PcHold, Instr, InstrPC, InstrValid, Done
    );

    // Environment side (PC, ROM, decode, program control)
    modport master (
        output Start, ProgCtr, Flush, Stall, Imem_Data,
        input  Imem_Addr, Imem_Rd, PcHold, Instr, InstrPC, InstrValid, Done
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: issues ROM reads from ProgCtr, registers the returned word with
// its PC behind a valid/stall handshake with a one-entry skid buffer, squashes on Flush and
// stops on the HALT opcode.
module instr_fetch_stage #(
    parameter int             A       = 10,
    parameter int             W       = 9,
    parameter logic [W-1:0]   HALT_OP = 9'h1FF
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    instr_fetch_stage_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

    state_t       state_q, state_d;
    logic         start_q;
    logic         rd_pend_q, rd_pend_d;
    logic [A-1:0] pend_pc_q, pend_pc_d;
    logic         skid_full_q, skid_full_d;
    logic [W-1:0] skid_q, skid_d;
    logic [A-1:0] skid_pc_q, skid_pc_d;
    logic [W-1:0] instr_q, instr_d;
    logic [A-1:0] instr_pc_q, instr_pc_d;
    logic         valid_q, valid_d;
    logic         done_q, done_d;

    logic launch;
    logic imem_rd;
    logic halt_acc;

    // Falling edge of Start launches (or restarts) a program.
    assign launch   = start_q & ~bus.Start;
    // A read is issued only when its word is guaranteed a place (skid empty, no stall).
    assign imem_rd  = (state_q == FETCH) & ~bus.Flush & ~bus.Stall & ~skid_full_q & ~launch;
    assign halt_acc = (state_q == FETCH) & valid_q & ~bus.Stall & (instr_q == HALT_OP);

    assign bus.Imem_Addr  = bus.ProgCtr;
    assign bus.Imem_Rd    = imem_rd;
    assign bus.PcHold     = ~imem_rd;
    assign bus.Instr      = instr_q;
    assign bus.InstrPC    = instr_pc_q;
    assign bus.InstrValid = valid_q;
    assign bus.Done       = done_q;

    // State and pipeline registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            pend_pc_q   <= '0;
            skid_full_q <= 1'b0;
            skid_q      <= '0;
            skid_pc_q   <= '0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= bus.Start;
            rd_pend_q   <= rd_pend_d;
            pend_pc_q   <= pend_pc_d;
            skid_full_q <= skid_full_d;
            skid_q      <= skid_d;
            skid_pc_q   <= skid_pc_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

    // Next state: launch > Flush > HALT accept > normal word movement.
    always_comb begin
        state_d     = state_q;
        rd_pend_d   = imem_rd;
        pend_pc_d   = bus.ProgCtr;
        skid_full_d = skid_full_q;
        skid_d      = skid_q;
        skid_pc_d   = skid_pc_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        valid_d     = valid_q;
        done_d      = done_q;

        if (launch) begin
            state_d     = FETCH;
            skid_full_d = 1'b0;
            rd_pend_d   = 1'b0;
            valid_d     = 1'b0;
            done_d      = 1'b0;
        end else if (bus.Flush) begin
            valid_d     = 1'b0;
            skid_full_d = 1'b0;
            rd_pend_d   = 1'b0;
        end else if (halt_acc) begin
            state_d     = HALTED;
            done_d      = 1'b1;
            valid_d     = 1'b0;
            skid_full_d = 1'b0;
            rd_pend_d   = 1'b0;
        end else if (rd_pend_q) begin
            if (!valid_q || !bus.Stall) begin
                valid_d = 1'b1;
                if (skid_full_q) begin
                    // Older skid word goes out first; the new word takes its place.
                    instr_d    = skid_q;
                    instr_pc_d = skid_pc_q;
                    skid_d     = bus.Imem_Data;
                    skid_pc_d  = pend_pc_q;
                end else begin
                    instr_d    = bus.Imem_Data;
                    instr_pc_d = pend_pc_q;
                end
            end else begin
                skid_full_d = 1'b1;
                skid_d      = bus.Imem_Data;
                skid_pc_d   = pend_pc_q;
            end
        end else if (!bus.Stall) begin
            valid_d     = skid_full_q;
            skid_full_d = 1'b0;
            if (skid_full_q) begin
                instr_d    = skid_q;
                instr_pc_d = skid_pc_q;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a modelled program counter and synchronous ROM.
module tb_instr_fetch_stage;
    logic       Clk;
    logic       Reset_n;
    logic [9:0] pc;
    logic [9:0] pc_tgt;
    logic       pc_load;
    logic [8:0] rom [0:1023];
    int         checks;
    int         failures;

    instr_fetch_stage_if #(.A(10), .W(9)) ifc ();

    instr_fetch_stage #(.A(10), .W(9), .HALT_OP(9'h1FF)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (ifc)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Program counter model: loads on branch/launch, advances only when not held.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)          pc <= '0;
        else if (pc_load)      pc <= pc_tgt;
        else if (!ifc.PcHold)  pc <= pc + 10'd1;
    end
    assign ifc.ProgCtr = pc;

    // Synchronous ROM, one-cycle read latency.
    always @(posedge Clk) begin
        if (ifc.Imem_Rd) ifc.Imem_Data <= rom[ifc.Imem_Addr];
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Start pulse 1->0 with the PC loaded to tgt; returns in cycle 1 (first read cycle).
    task automatic launch(input logic [9:0] tgt);
        ifc.Stall = 1'b0;
        ifc.Flush = 1'b0;
        ifc.Start = 1'b1;
        step();
        ifc.Start = 1'b0;
        pc_load   = 1'b1;
        pc_tgt    = tgt;
        #1;
        checks++;
        if (ifc.Imem_Rd !== 1'b0) begin
            failures++;
            $display("FAIL launch_no_rd got=%b exp=0", ifc.Imem_Rd);
        end
        step();
        pc_load = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (ifc.InstrValid !== 1'b0 || ifc.Instr !== 9'h000 || ifc.InstrPC !== 10'd0 ||
            ifc.Done !== 1'b0 || ifc.Imem_Rd !== 1'b0 || ifc.PcHold !== 1'b1) begin
            failures++;
            $display("FAIL reset_state got v=%b i=%h pc=%0d d=%b rd=%b hold=%b exp 0/000/0/0/0/1",
                     ifc.InstrValid, ifc.Instr, ifc.InstrPC, ifc.Done, ifc.Imem_Rd, ifc.PcHold);
        end
        step();
        step();
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ifc.Imem_Rd !== 1'b0 || ifc.InstrValid !== 1'b0) begin
                failures++;
                $display("FAIL idle_no_rd cyc=%0d got rd=%b v=%b exp 0/0", i, ifc.Imem_Rd, ifc.InstrValid);
            end
        end
    endtask

    task automatic test_basic();
        logic [8:0] exp_i [0:3];
        exp_i[0] = 9'h0A1; exp_i[1] = 9'h0B2; exp_i[2] = 9'h0C3; exp_i[3] = 9'h0D4;
        launch(10'd0);
        checks++;
        if (ifc.Imem_Rd !== 1'b1 || ifc.Imem_Addr !== 10'd0) begin
            failures++;
            $display("FAIL basic_first_rd got rd=%b addr=%0d exp 1/0", ifc.Imem_Rd, ifc.Imem_Addr);
        end
        step();
        checks++;
        if (ifc.InstrValid !== 1'b0) begin
            failures++;
            $display("FAIL basic_c2_bubble got v=%b exp 0", ifc.InstrValid);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (ifc.InstrValid !== 1'b1 || ifc.Instr !== exp_i[k] || ifc.InstrPC !== 10'(k)) begin
                failures++;
                $display("FAIL basic_word%0d got v=%b i=%h pc=%0d exp 1/%h/%0d",
                         k, ifc.InstrValid, ifc.Instr, ifc.InstrPC, exp_i[k], k);
            end
        end
    endtask

    task automatic test_stall();
        launch(10'd0);
        step();                       // c2
        step();                       // c3: A valid, B in flight
        ifc.Stall = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ifc.InstrValid !== 1'b1 || ifc.Instr !== 9'h0A1 || ifc.Imem_Rd !== 1'b0 || ifc.PcHold !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold%0d got v=%b i=%h rd=%b hold=%b exp 1/0a1/0/1",
                         k, ifc.InstrValid, ifc.Instr, ifc.Imem_Rd, ifc.PcHold);
            end
            if (k < 2) step();
        end
        step();                       // c6: release, A consumed, skid still full
        ifc.Stall = 1'b0;
        #1;
        checks++;
        if (ifc.InstrValid !== 1'b1 || ifc.Instr !== 9'h0A1 || ifc.Imem_Rd !== 1'b0) begin
            failures++;
            $display("FAIL stall_release got v=%b i=%h rd=%b exp 1/0a1/0", ifc.InstrValid, ifc.Instr, ifc.Imem_Rd);
        end
        step();                       // c7: B from skid, read of pc 2
        checks++;
        if (ifc.InstrValid !== 1'b1 || ifc.Instr !== 9'h0B2 || ifc.InstrPC !== 10'd1 ||
            ifc.Imem_Rd !== 1'b1 || ifc.Imem_Addr !== 10'd2) begin
            failures++;
            $display("FAIL stall_skid_B got v=%b i=%h pc=%0d rd=%b addr=%0d exp 1/0b2/1/1/2",
                     ifc.InstrValid, ifc.Instr, ifc.InstrPC, ifc.Imem_Rd, ifc.Imem_Addr);
        end
        step();                       // c8: bubble
        checks++;
        if (ifc.InstrValid !== 1'b0) begin
            failures++;
            $display("FAIL stall_bubble got v=%b exp 0", ifc.InstrValid);
        end
        step();                       // c9: C
        checks++;
        if (ifc.InstrValid !== 1'b1 || ifc.Instr !== 9'h0C3 || ifc.InstrPC !== 10'd2) begin
            failures++;
            $display("FAIL stall_C got v=%b i=%h pc=%0d exp 1/0c3/2", ifc.InstrValid, ifc.Instr, ifc.InstrPC);
        end
        step();                       // c10: D
        checks++;
        if (ifc.InstrValid !== 1'b1 || ifc.Instr !== 9'h0D4 || ifc.InstrPC !== 10'd3) begin
            failures++;
            $display("FAIL stall_D got v=%b i=%h pc=%0d exp 1/0d4/3", ifc.InstrValid, ifc.Instr, ifc.InstrPC);
        end
    endtask

    task automatic test_flush();
        launch(10'd0);
        step();                       // c2
        step();                       // c3: A valid, B in flight; branch to 40 with stall
        ifc.Flush = 1'b1;
        ifc.Stall = 1'b1;
        pc_load   = 1'b1;
        pc_tgt    = 10'd40;
        #1;
        checks++;
        if (ifc.Imem_Rd !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_rd got=%b exp=0", ifc.Imem_Rd);
        end
        step();                       // c4
        ifc.Flush = 1'b0;
        ifc.Stall = 1'b0;
        pc_load   = 1'b0;
        #1;
        checks++;
        if (ifc.InstrValid !== 1'b0 || ifc.Imem_Rd !== 1'b1 || ifc.Imem_Addr !== 10'd40) begin
            failures++;
            $display("FAIL flush_squash got v=%b rd=%b addr=%0d exp 0/1/40", ifc.InstrValid, ifc.Imem_Rd, ifc.Imem_Addr);
        end
        step();                       // c5
        checks++;
        if (ifc.InstrValid !== 1'b0) begin
            failures++;
            $display("FAIL flush_B_dropped got v=%b exp 0", ifc.InstrValid);
        end
        step();                       // c6
        checks++;
        if (ifc.InstrValid !== 1'b1 || ifc.InstrPC !== 10'd40 || ifc.Instr !== 9'h028) begin
            failures++;
            $display("FAIL flush_target got v=%b pc=%0d i=%h exp 1/40/028", ifc.InstrValid, ifc.InstrPC, ifc.Instr);
        end
    endtask

    task automatic test_halt();
        rom[3] = 9'h1FF;
        launch(10'd0);
        for (int k = 0; k < 4; k++) step();   // c2..c5
        step();                               // c6: HALT valid
        checks++;
        if (ifc.InstrValid !== 1'b1 || ifc.Instr !== 9'h1FF || ifc.InstrPC !== 10'd3 || ifc.Done !== 1'b0) begin
            failures++;
            $display("FAIL halt_word got v=%b i=%h pc=%0d d=%b exp 1/1ff/3/0",
                     ifc.InstrValid, ifc.Instr, ifc.InstrPC, ifc.Done);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (ifc.InstrValid !== 1'b0 || ifc.Done !== 1'b1 || ifc.Imem_Rd !== 1'b0 || ifc.PcHold !== 1'b1) begin
                failures++;
                $display("FAIL halted%0d got v=%b d=%b rd=%b hold=%b exp 0/1/0/1",
                         k, ifc.InstrValid, ifc.Done, ifc.Imem_Rd, ifc.PcHold);
            end
        end
    endtask

    task automatic test_relaunch();
        launch(10'd100);
        checks++;
        if (ifc.Done !== 1'b0 || ifc.Imem_Rd !== 1'b1 || ifc.Imem_Addr !== 10'd100) begin
            failures++;
            $display("FAIL relaunch got d=%b rd=%b addr=%0d exp 0/1/100", ifc.Done, ifc.Imem_Rd, ifc.Imem_Addr);
        end
        step();
        step();
        checks++;
        if (ifc.InstrValid !== 1'b1 || ifc.InstrPC !== 10'd100 || ifc.Instr !== 9'h064 || ifc.Done !== 1'b0) begin
            failures++;
            $display("FAIL relaunch_word got v=%b pc=%0d i=%h d=%b exp 1/100/064/0",
                     ifc.InstrValid, ifc.InstrPC, ifc.Instr, ifc.Done);
        end
    endtask

    task automatic test_reset_midfetch();
        launch(10'd0);
        step();                       // c2
        step();                       // c3: stall so B lands in the skid
        ifc.Stall = 1'b1;
        step();                       // c4: skid full
        Reset_n = 1'b0;
        #1;
        checks++;
        if (ifc.InstrValid !== 1'b0 || ifc.Instr !== 9'h000 || ifc.InstrPC !== 10'd0 ||
            ifc.Done !== 1'b0 || ifc.Imem_Rd !== 1'b0 || ifc.PcHold !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got v=%b i=%h pc=%0d d=%b rd=%b hold=%b exp 0/000/0/0/0/1",
                     ifc.InstrValid, ifc.Instr, ifc.InstrPC, ifc.Done, ifc.Imem_Rd, ifc.PcHold);
        end
        step();
        Reset_n   = 1'b1;
        ifc.Stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ifc.Imem_Rd !== 1'b0 || ifc.InstrValid !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_idle cyc=%0d got rd=%b v=%b exp 0/0", i, ifc.Imem_Rd, ifc.InstrValid);
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        Reset_n   = 1'b0;
        pc_load   = 1'b0;
        pc_tgt    = '0;
        ifc.Start = 1'b0;
        ifc.Flush = 1'b0;
        ifc.Stall = 1'b0;
        for (int i = 0; i < 1024; i++) rom[i] = {1'b0, i[7:0]};
        rom[0] = 9'h0A1;
        rom[1] = 9'h0B2;
        rom[2] = 9'h0C3;
        rom[3] = 9'h0D4;

        test_reset();
        test_basic();
        test_stall();
        test_flush();
        test_halt();
        test_relaunch();
        test_reset_midfetch();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
